// File: rtl/fx_log_arbiter.sv
// Round-robin arbiter sharing one external combinational fx_log datapath between NUM_REQ
// requesters, with a registered operand, a programmable settle time and a tagged response.
module fx_log_arbiter #(
  parameter int  NUM_REQ     = 4,
  parameter int  LOG_LATENCY = 1,
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*32-1:0] req_arg,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_err,
  output logic [31:0]          log_argument,
  input  logic [31:0]          log_result,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] LOG_ZERO_SAT = 32'h8000_0000;
  localparam logic [3:0]  WAIT_INIT    = 4'(LOG_LATENCY - 1);

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [3:0]      wait_cnt;

  logic            found;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] next_ptr;
  logic [31:0]     grant_arg;
  logic            accept;
  int              slot;

  // Rotating priority search starting at rr_ptr.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    found = 1'b0;
    grant = '0;
    slot  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = int'(rr_ptr) + k;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      if (!found && req_valid[slot[ID_W-1:0]]) begin
        found = 1'b1;
        grant = slot[ID_W-1:0];
      end
    end
  end

  always_comb begin
    grant_arg = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant == ID_W'(k)) grant_arg = req_arg[32*k +: 32];
    end
  end

  // The ready vector is masked while rst is high so no requester sees an accept during reset.
  assign accept   = (state == IDLE) && found && !rst;
  assign next_ptr = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready[k] = accept && (grant == ID_W'(k));
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples the
  // pre-edge values and the order of statements cannot create hidden ordering hazards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      wait_cnt     <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_id       <= '0;
      rsp_err      <= 1'b0;
      log_argument <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_id <= grant;
            rr_ptr <= next_ptr;
            busy   <= 1'b1;
            if (grant_arg != '0) begin
              log_argument <= grant_arg;
              wait_cnt     <= WAIT_INIT;
              state        <= WAIT;
            end else begin
              // log(0) is undefined: answer at once with the saturated value and the error flag.
              rsp_data  <= LOG_ZERO_SAT;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            rsp_data  <= log_result;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fx_log_arbiter.sv
// Directed bench for fx_log_arbiter: one LOG_LATENCY=1 instance and one LOG_LATENCY=4 instance,
// each fed by a stand-in fx_log datapath.
module tb_fx_log_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_ready, req_valid4, req_ready4;
  logic [N*32-1:0] req_arg, req_arg4;
  logic           rsp_valid, rsp_ready, rsp_err, busy;
  logic           rsp_valid4, rsp_ready4, rsp_err4, busy4;
  logic [31:0]    rsp_data, log_argument, log_result;
  logic [31:0]    rsp_data4, log_argument4, log_result4;
  logic [1:0]     rsp_id, rsp_id4;

  int tests    = 0;
  int failures = 0;

  // Stand-in for the external fx_log datapath; the arbiter only has to forward its output.
  function automatic logic [31:0] fx_log_model(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] arg_of(input int i);
    return 32'h0001_0000 + 32'(i) * 32'h03FF_0000;
  endfunction

  assign log_result  = fx_log_model(log_argument);
  assign log_result4 = fx_log_model(log_argument4);

  fx_log_arbiter #(.NUM_REQ(N), .LOG_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_arg(req_arg), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err),
    .log_argument(log_argument), .log_result(log_result), .busy(busy)
  );

  fx_log_arbiter #(.NUM_REQ(N), .LOG_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid4), .req_arg(req_arg4), .req_ready(req_ready4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_data(rsp_data4),
    .rsp_id(rsp_id4), .rsp_err(rsp_err4),
    .log_argument(log_argument4), .log_result(log_result4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};

    rst        = 1'b1;
    req_valid  = '0;
    req_arg    = '0;
    rsp_ready  = 1'b1;
    req_valid4 = '0;
    req_arg4   = '0;
    rsp_ready4 = 1'b1;
    tick();
    tick();
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_log_argument", log_argument, 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    rst = 1'b0;
    tick();

    // Single request from requester 0, argument 1.0.
    req_arg[31:0] = 32'h0001_0000;
    req_valid     = 4'b0001;
    #1 check("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("single_busy", 32'(busy), 32'd1);
    check("single_valid_T1", 32'(rsp_valid), 32'd0);
    check("single_log_arg", log_argument, 32'h0001_0000);
    check("single_ready_wait", 32'(req_ready), 32'd0);
    tick();
    check("single_valid_T2", 32'(rsp_valid), 32'd1);
    check("single_id", 32'(rsp_id), 32'd0);
    check("single_err", 32'(rsp_err), 32'd0);
    check("single_data", rsp_data, fx_log_model(32'h0001_0000));
    tick();
    check("single_valid_drop", 32'(rsp_valid), 32'd0);
    check("single_idle", 32'(busy), 32'd0);

    // Zero argument from requester 2; rr_ptr is now 1 so requester 2 is the first valid one.
    req_arg[95:64] = 32'h0;
    req_valid      = 4'b0100;
    #1 check("zero_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    check("zero_valid_T1", 32'(rsp_valid), 32'd1);
    check("zero_data", rsp_data, 32'h8000_0000);
    check("zero_err", 32'(rsp_err), 32'd1);
    check("zero_id", 32'(rsp_id), 32'd2);
    check("zero_log_arg_held", log_argument, 32'h0001_0000);
    tick();
    check("zero_valid_drop", 32'(rsp_valid), 32'd0);

    // Reset pulse in the middle of WAIT for a requester-3 transaction.
    req_arg[127:96] = 32'h0002_0000;
    req_valid       = 4'b1000;
    #1 check("rst_ready_grant3", 32'(req_ready), 32'h8);
    tick();
    check("rst_in_wait_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_log_arg", log_argument, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("rst_no_response", 32'(rsp_valid), 32'd0);
    end

    // Round-robin with every requester held valid; rr_ptr restarts at 0 after reset.
    for (int i = 0; i < N; i++) req_arg[32*i +: 32] = arg_of(i);
    req_valid = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      check("rr_grant", 32'(req_ready), 32'(1) << order[g]);
      tick();
      check("rr_ready_wait", 32'(req_ready), 32'd0);
      check("rr_valid_T1", 32'(rsp_valid), 32'd0);
      tick();
      check("rr_valid_T2", 32'(rsp_valid), 32'd1);
      check("rr_id", 32'(rsp_id), 32'(order[g]));
      check("rr_data", rsp_data, fx_log_model(arg_of(order[g])));
      check("rr_err", 32'(rsp_err), 32'd0);
      tick();
    end
    req_valid = '0;

    // Backpressure: rr_ptr is 1, requesters 1 and 3 pending, consumer stalled for 20 cycles.
    rsp_ready = 1'b0;
    req_valid = 4'b1010;
    #1 check("bp_grant1", 32'(req_ready), 32'h2);
    tick();
    tick();
    check("bp_valid", 32'(rsp_valid), 32'd1);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_data", rsp_data, fx_log_model(arg_of(1)));
      check("bp_hold_id", 32'(rsp_id), 32'd1);
      check("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1 check("bp_no_accept_in_handshake", 32'(req_ready), 32'd0);
    tick();
    check("bp_valid_drop", 32'(rsp_valid), 32'd0);
    check("bp_next_grant3", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    check("bp_next_busy", 32'(busy), 32'd1);
    check("bp_single_handshake", 32'(rsp_valid), 32'd0);
    tick();
    check("bp_next_valid", 32'(rsp_valid), 32'd1);
    check("bp_next_id", 32'(rsp_id), 32'd3);
    check("bp_next_data", rsp_data, fx_log_model(arg_of(3)));
    tick();
    check("bp_final_idle", 32'(busy), 32'd0);

    // LOG_LATENCY=4 instance: argument sweep, response expected at T+5.
    for (int i = 0; i < 10; i++) begin
      req_arg4[31:0] = arg_of(i);
      req_valid4     = 4'b0001;
      #1 check("lat4_ready", 32'(req_ready4), 32'h1);
      for (int c = 1; c <= 5; c++) begin
        tick();
        if (c == 1) req_valid4 = '0;
        check("lat4_valid_timing", 32'(rsp_valid4), 32'(c == 5));
      end
      check("lat4_data", rsp_data4, fx_log_model(arg_of(i)));
      check("lat4_err", 32'(rsp_err4), 32'd0);
      check("lat4_id", 32'(rsp_id4), 32'd0);
      tick();
      check("lat4_valid_drop", 32'(rsp_valid4), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
